// File: rtl/addsub_issue_64_pkg.sv
// rtl/addsub_issue_64_pkg.sv - shared widths, op encoding and retire entry
package addsub_issue_64_pkg;

  localparam int XLEN      = 64;
  localparam int TAG_W_MAX = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Tag field is sized for the widest supported tag; narrower tags zero-extend.
  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic                 ovf;
    logic [TAG_W_MAX-1:0] tag;
  } retire_t;

endpackage

// File: rtl/addsub_issue_64_adder.sv
// rtl/addsub_issue_64_adder.sv - adder_64: registered 64-bit wrap adder with carry/overflow flag
module adder_64
  import addsub_issue_64_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sign,
  output logic [XLEN-1:0] sum_q,
  output logic            carry_q
);

  logic [XLEN:0]   wide;
  logic [XLEN-1:0] sum_d;
  logic            carry_d;

  always_comb begin
    wide    = {1'b0, a} + {1'b0, b};
    sum_d   = wide[XLEN-1:0];
    carry_d = sign ? ((a[XLEN-1] == b[XLEN-1]) && (sum_d[XLEN-1] != a[XLEN-1]))
                   : wide[XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/addsub_issue_64.sv
// rtl/addsub_issue_64.sv - issue/retire stage around adder_64 with credit-controlled in-order result queue
module addsub_issue_64
  import addsub_issue_64_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic             req_sub,
  input  logic             req_signed,
  input  logic [TAG_W-1:0] req_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic             res_ovf,
  output logic [TAG_W-1:0] res_tag
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + 3);

  logic [XLEN-1:0]  x_q, x_d, y_q, y_d;
  logic             s1_v_q, s1_v_d, s1_sub_q, s1_sub_d, s1_signed_q, s1_signed_d;
  logic             s1_a63_q, s1_a63_d, s1_b63_q, s1_b63_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_v_q, s2_v_d, s2_sub_q, s2_sub_d, s2_signed_q, s2_signed_d;
  logic             s2_a63_q, s2_a63_d, s2_b63_q, s2_b63_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic [XLEN-1:0]  sum;
  logic             carry;

  retire_t          mem_q [DEPTH];
  retire_t          mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]    count_q, count_d;

  logic [OW-1:0]    occupancy;
  logic             accept, push, pop;
  logic [XLEN-1:0]  r;
  logic             ovf;
  retire_t          wr_ent;

  // Adder only adds; subtraction uses A-B = ~(~A+B) so carry doubles as borrow.
  adder_64 u_adder (
    .clk    (clk),
    .rst    (rst),
    .a      (x_q),
    .b      (y_q),
    .sign   (1'b0),
    .sum_q  (sum),
    .carry_q(carry)
  );

  always_comb begin
    occupancy = OW'(count_q) + OW'(s1_v_q) + OW'(s2_v_q);
    req_ready = !rst && !flush && (occupancy < OW'(DEPTH));
    accept    = req_valid && req_ready;
    res_valid = (count_q != '0);
    push      = s2_v_q && !flush;
    pop       = res_valid && res_ready && !flush;
    res_data  = mem_q[rd_ptr_q].data;
    res_ovf   = mem_q[rd_ptr_q].ovf;
    res_tag   = mem_q[rd_ptr_q].tag[TAG_W-1:0];
  end

  always_comb begin
    r = (s2_sub_q == OP_ADD) ? sum : ~sum;
    if (!s2_signed_q)
      ovf = carry;
    else if (s2_sub_q == OP_SUB)
      ovf = (s2_a63_q != s2_b63_q) && (r[XLEN-1] != s2_a63_q);
    else
      ovf = (s2_a63_q == s2_b63_q) && (r[XLEN-1] != s2_a63_q);
    wr_ent      = '0;
    wr_ent.data = r;
    wr_ent.ovf  = ovf;
    wr_ent.tag  = TAG_W_MAX'(s2_tag_q);
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    s1_sub_d    = s1_sub_q;
    s1_signed_d = s1_signed_q;
    s1_tag_d    = s1_tag_q;
    s1_a63_d    = s1_a63_q;
    s1_b63_d    = s1_b63_q;
    if (accept) begin
      x_d         = (req_sub == OP_SUB) ? ~req_a : req_a;
      y_d         = req_b;
      s1_sub_d    = req_sub;
      s1_signed_d = req_signed;
      s1_tag_d    = req_tag;
      s1_a63_d    = req_a[XLEN-1];
      s1_b63_d    = req_b[XLEN-1];
    end
    s1_v_d      = accept;
    s2_v_d      = s1_v_q && !flush;
    s2_sub_d    = s1_sub_q;
    s2_signed_d = s1_signed_q;
    s2_tag_d    = s1_tag_q;
    s2_a63_d    = s1_a63_q;
    s2_b63_d    = s1_b63_q;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_ent;
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + QW'(push) - QW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      s1_v_q      <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_signed_q <= 1'b0;
      s1_tag_q    <= '0;
      s1_a63_q    <= 1'b0;
      s1_b63_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_sub_q    <= 1'b0;
      s2_signed_q <= 1'b0;
      s2_tag_q    <= '0;
      s2_a63_q    <= 1'b0;
      s2_b63_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      s1_v_q      <= s1_v_d;
      s1_sub_q    <= s1_sub_d;
      s1_signed_q <= s1_signed_d;
      s1_tag_q    <= s1_tag_d;
      s1_a63_q    <= s1_a63_d;
      s1_b63_q    <= s1_b63_d;
      s2_v_q      <= s2_v_d;
      s2_sub_q    <= s2_sub_d;
      s2_signed_q <= s2_signed_d;
      s2_tag_q    <= s2_tag_d;
      s2_a63_q    <= s2_a63_d;
      s2_b63_q    <= s2_b63_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

endmodule
